mul_div_unit: RTL

//   Multi-cycle execute-stage unit that consumes the MULHU/DIVU/REMU controls from function control
//   (unit_select 3'b100 / 3'b101, mul_op, div_op) and returns a 32-bit result.

---
 rtl/mul_div_unit_pkg.sv | 32 +++
 rtl/restoring_div_step.sv | 29 ++
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module   : mul_div_unit_pkg
// Purpose  : Shared encodings for the multi-cycle MULHU/DIVU/REMU unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mul_div_unit_pkg;

  // unit_select encodings, shared with function control and the ALU result mux
  localparam logic [2:0] c_UNIT_ARITH = 3'b000;
  localparam logic [2:0] c_UNIT_LOGIC = 3'b001;
  localparam logic [2:0] c_UNIT_SHIFT = 3'b010;
  localparam logic [2:0] c_UNIT_CMP   = 3'b011;
  localparam logic [2:0] c_UNIT_MUL   = 3'b100;
  localparam logic [2:0] c_UNIT_DIV   = 3'b101;

  localparam logic [4:0] c_OP_MULHU = 5'd15;
  localparam logic [4:0] c_OP_DIVU  = 5'd16;
  localparam logic [4:0] c_OP_REMU  = 5'd17;

  localparam logic c_DIV_QUOT = 1'b0;
  localparam logic c_DIV_REM  = 1'b1;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_MUL  = 2'd1;
  localparam logic [1:0] c_S_DIV  = 2'd2;
  localparam logic [1:0] c_S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/restoring_div_step.sv
// ============================================================================
// Module   : restoring_div_step
// Purpose  : One combinational radix-2 restoring division step.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module restoring_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_next_o,
  output logic [XLEN-1:0] quot_next_o
);

  // One extra bit keeps the shifted-in dividend bit from overflowing the compare
  logic [XLEN:0] w_shift;
  logic          w_ge;

  assign w_shift     = {rem_i, quot_i[XLEN-1]};
  assign w_ge        = (w_shift >= {1'b0, divisor_i});
  assign rem_next_o  = w_ge ? (w_shift[XLEN-1:0] - divisor_i) : w_shift[XLEN-1:0];
  assign quot_next_o = {quot_i[XLEN-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative MULHU (shift-add) / DIVU / REMU (restoring) unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      unit_select,
  input  logic            mul_op,
  input  logic            div_op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic              op_rem_q, op_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_accept;
  logic              w_is_mul;
  logic              w_last;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quot_next;

  assign w_is_mul = (unit_select == c_UNIT_MUL) && mul_op;
  assign w_accept = (state_q == c_S_IDLE) && valid_i && !flush &&
                    (w_is_mul || (unit_select == c_UNIT_DIV));
  assign w_last   = (cnt_q == c_CNT_LAST);

  // Carry out of the upper-half add is shifted back into the accumulator MSB
  assign w_sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign w_acc_next = {w_sum, acc_q[XLEN-1:1]};

  restoring_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_i       (rem_q),
    .quot_i      (quot_q),
    .divisor_i   (divisor_q),
    .rem_next_o  (w_rem_next),
    .quot_next_o (w_quot_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    op_rem_d  = op_rem_q;
    result_d  = result_q;

    case (state_q)
      c_S_IDLE: begin
        if (w_accept) begin
          cnt_d = '0;
          if (w_is_mul) begin
            acc_d   = {{XLEN{1'b0}}, operand_b};
            mcand_d = operand_a;
            state_d = c_S_MUL;
          end else begin
            rem_d     = '0;
            quot_d    = operand_a;
            divisor_d = operand_b;
            op_rem_d  = div_op;
            if (operand_b == '0) begin
              result_d = (div_op == c_DIV_REM) ? operand_a : '1;
              state_d  = c_S_DONE;
            end else begin
              state_d = c_S_DIV;
            end
          end
        end
      end
      c_S_MUL: begin
        acc_d = w_acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (w_last) begin
          result_d = w_acc_next[2*XLEN-1:XLEN];
          state_d  = c_S_DONE;
        end
      end
      c_S_DIV: begin
        rem_d  = w_rem_next;
        quot_d = w_quot_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (w_last) begin
          result_d = (op_rem_q == c_DIV_REM) ? w_rem_next : w_quot_next;
          state_d  = c_S_DONE;
        end
      end
      default: state_d = c_S_IDLE;
    endcase

    // Abort wins over completion: no result is published for a flushed op
    if (flush && (state_q != c_S_IDLE)) begin
      state_d  = c_S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      op_rem_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      op_rem_q  <= op_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy_o         = (state_q != c_S_IDLE);
  assign result_valid_o = (state_q == c_S_DONE);
  assign result_o       = result_q;

endmodule

`default_nettype wire
